// File: rtl/servo_cmd_scheduler.sv
// Servo command scheduler: arbitrates CPU/button commands and an autonomous sweep
// onto the pwm generator DIN input, with a hold/settle sequence per command.
module servo_cmd_scheduler #(
    parameter int HOLD         = 2,
    parameter int SETTLE       = 16'd50000,
    parameter int STEPS        = 80,
    parameter int NEUTRAL_STEP = 40
) (
    input  logic       SCLK,
    input  logic       RESET,
    input  logic       CPU_REQ,
    input  logic [2:0] CPU_CMD,
    input  logic       BTN_REQ,
    input  logic [2:0] BTN_CMD,
    input  logic       SWEEP_EN,
    output logic [2:0] DIN,
    output logic       CPU_ACK,
    output logic       BTN_ACK,
    output logic       CMD_ERR,
    output logic       BUSY,
    output logic [6:0] STEP_CNT
);

    // state    | meaning
    // S_IDLE   | waiting for a request or sweep slot
    // S_ISSUE  | driving the granted command on DIN for HOLD cycles
    // S_SETTLE | DIN=0 while the servo settles for SETTLE cycles

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_SETTLE} state_t;

    localparam logic [2:0]  CMD_LEFT    = 3'b100;
    localparam logic [2:0]  CMD_NEUTRAL = 3'b010;
    localparam logic [2:0]  CMD_RIGHT   = 3'b001;
    localparam logic [15:0] HOLD_LD     = 16'(HOLD - 1);
    localparam logic [15:0] SETTLE_LD   = 16'(SETTLE - 1);
    localparam logic [6:0]  STEPS_C     = 7'(STEPS);
    localparam logic [6:0]  NEUTRAL_C   = 7'(NEUTRAL_STEP);

    state_t      state, state_nxt;
    logic [15:0] tmr, tmr_nxt;
    logic        rr_btn, rr_btn_nxt;

    logic [2:0]  din_nxt;
    logic        cpu_ack_nxt, btn_ack_nxt, cmd_err_nxt, busy_nxt;
    logic [6:0]  step_nxt;

    logic        any_req, pick_btn, grant_ok, start, cmd_valid, launch;
    logic [2:0]  req_cmd, sweep_cmd, issue_cmd;

    function automatic logic is_onehot(input logic [2:0] c);
        return (c == CMD_LEFT) || (c == CMD_NEUTRAL) || (c == CMD_RIGHT);
    endfunction

    function automatic logic [6:0] step_after(input logic [2:0] c, input logic [6:0] cur);
        logic [6:0] r;
        case (c)
            CMD_LEFT:    r = 7'd0;
            CMD_NEUTRAL: r = NEUTRAL_C;
            CMD_RIGHT:   r = (cur >= STEPS_C) ? STEPS_C : cur + 7'd1;
            default:     r = cur;
        endcase
        return r;
    endfunction

    // A registered ACK means the requester still sees its REQ high this cycle,
    // so the acknowledge cycle is never a grant opportunity.
    always_comb begin
        any_req   = CPU_REQ || BTN_REQ;
        pick_btn  = BTN_REQ && (!CPU_REQ || rr_btn);
        req_cmd   = pick_btn ? BTN_CMD : CPU_CMD;
        sweep_cmd = (STEP_CNT < STEPS_C) ? CMD_RIGHT : CMD_LEFT;
        issue_cmd = any_req ? req_cmd : sweep_cmd;
        cmd_valid = is_onehot(issue_cmd);
        grant_ok  = (state == S_IDLE) && !CPU_ACK && !BTN_ACK;
        start     = grant_ok && (any_req || SWEEP_EN);
        launch    = start && cmd_valid;
    end

    always_ff @(posedge SCLK) begin
        if (RESET) begin
            state    <= S_IDLE;
            tmr      <= '0;
            rr_btn   <= 1'b0;
            DIN      <= '0;
            CPU_ACK  <= 1'b0;
            BTN_ACK  <= 1'b0;
            CMD_ERR  <= 1'b0;
            BUSY     <= 1'b0;
            STEP_CNT <= '0;
        end else begin
            state    <= state_nxt;
            tmr      <= tmr_nxt;
            rr_btn   <= rr_btn_nxt;
            DIN      <= din_nxt;
            CPU_ACK  <= cpu_ack_nxt;
            BTN_ACK  <= btn_ack_nxt;
            CMD_ERR  <= cmd_err_nxt;
            BUSY     <= busy_nxt;
            STEP_CNT <= step_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        tmr_nxt    = tmr;
        rr_btn_nxt = rr_btn;
        case (state)
            S_IDLE: begin
                if (start && any_req)
                    rr_btn_nxt = !pick_btn;
                if (launch) begin
                    state_nxt = S_ISSUE;
                    tmr_nxt   = HOLD_LD;
                end
            end
            S_ISSUE: begin
                if (tmr == 16'd0) begin
                    state_nxt = S_SETTLE;
                    tmr_nxt   = SETTLE_LD;
                end else begin
                    tmr_nxt = tmr - 16'd1;
                end
            end
            S_SETTLE: begin
                if (tmr == 16'd0) begin
                    state_nxt = S_IDLE;
                    tmr_nxt   = 16'd0;
                end else begin
                    tmr_nxt = tmr - 16'd1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                tmr_nxt   = 16'd0;
            end
        endcase
    end

    always_comb begin
        din_nxt     = 3'd0;
        cpu_ack_nxt = start && any_req && !pick_btn;
        btn_ack_nxt = start && any_req && pick_btn;
        cmd_err_nxt = start && !cmd_valid;
        busy_nxt    = (state_nxt != S_IDLE);
        step_nxt    = STEP_CNT;
        if (state_nxt == S_ISSUE)
            din_nxt = (state == S_IDLE) ? issue_cmd : DIN;
        if (launch)
            step_nxt = step_after(issue_cmd, STEP_CNT);
    end

endmodule

// File: tb/tb_servo_cmd_scheduler.sv
// Directed bench for servo_cmd_scheduler with HOLD=2, SETTLE=5, STEPS=3, NEUTRAL_STEP=1.
module tb_servo_cmd_scheduler;

    localparam int HOLD   = 2;
    localparam int SETTLE = 5;

    logic       SCLK = 1'b0;
    logic       RESET;
    logic       CPU_REQ, BTN_REQ, SWEEP_EN;
    logic [2:0] CPU_CMD, BTN_CMD;
    logic [2:0] DIN;
    logic       CPU_ACK, BTN_ACK, CMD_ERR, BUSY;
    logic [6:0] STEP_CNT;

    int n_checks = 0;
    int n_fail   = 0;

    servo_cmd_scheduler #(
        .HOLD(HOLD), .SETTLE(SETTLE), .STEPS(3), .NEUTRAL_STEP(1)
    ) dut (
        .SCLK(SCLK), .RESET(RESET),
        .CPU_REQ(CPU_REQ), .CPU_CMD(CPU_CMD),
        .BTN_REQ(BTN_REQ), .BTN_CMD(BTN_CMD),
        .SWEEP_EN(SWEEP_EN),
        .DIN(DIN), .CPU_ACK(CPU_ACK), .BTN_ACK(BTN_ACK),
        .CMD_ERR(CMD_ERR), .BUSY(BUSY), .STEP_CNT(STEP_CNT)
    );

    always #5 SCLK = ~SCLK;

    typedef struct {
        logic       btn;
        logic [2:0] cmd;
        logic       ok;
        logic [6:0] step;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge SCLK);
        RESET = 1'b1;
        @(posedge SCLK);
        @(negedge SCLK);
        RESET = 1'b0;
    endtask

    // One request, then its whole hold/settle sequence back to an idle cycle.
    task automatic run_vec(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("vec%0d", idx);
        @(negedge SCLK);
        if (v.btn) begin BTN_REQ = 1'b1; BTN_CMD = v.cmd; end
        else       begin CPU_REQ = 1'b1; CPU_CMD = v.cmd; end
        @(posedge SCLK); #1;
        chk({tag, "_cpu_ack"}, CPU_ACK, !v.btn);
        chk({tag, "_btn_ack"}, BTN_ACK, v.btn);
        chk({tag, "_err"}, CMD_ERR, !v.ok);
        chk({tag, "_din"}, DIN, v.ok ? v.cmd : 0);
        chk({tag, "_busy"}, BUSY, v.ok);
        chk({tag, "_step"}, STEP_CNT, v.step);
        @(negedge SCLK);
        CPU_REQ = 1'b0;
        BTN_REQ = 1'b0;
        if (v.ok) begin
            for (int k = 2; k <= HOLD; k++) begin
                @(posedge SCLK); #1;
                chk({tag, "_hold_din"}, DIN, v.cmd);
            end
            for (int k = 1; k <= SETTLE; k++) begin
                @(posedge SCLK); #1;
                chk({tag, "_settle_din"}, DIN, 0);
                chk({tag, "_settle_busy"}, BUSY, 1);
            end
        end
        @(posedge SCLK); #1;
        chk({tag, "_idle_busy"}, BUSY, 0);
        chk({tag, "_idle_din"}, DIN, 0);
        chk({tag, "_idle_ack"}, CPU_ACK | BTN_ACK | CMD_ERR, 0);
    endtask

    initial begin
        logic [2:0] sw_cmd[4];
        logic [6:0] sw_step[4];
        int p, s;

        RESET = 1'b0; CPU_REQ = 1'b0; BTN_REQ = 1'b0; SWEEP_EN = 1'b0;
        CPU_CMD = 3'd0; BTN_CMD = 3'd0;

        vecs[0]  = '{1'b0, 3'd4, 1'b1, 7'd0};
        vecs[1]  = '{1'b0, 3'd1, 1'b1, 7'd1};
        vecs[2]  = '{1'b1, 3'd1, 1'b1, 7'd2};
        vecs[3]  = '{1'b0, 3'd1, 1'b1, 7'd3};
        vecs[4]  = '{1'b1, 3'd1, 1'b1, 7'd3};
        vecs[5]  = '{1'b0, 3'd1, 1'b1, 7'd3};
        vecs[6]  = '{1'b1, 3'd1, 1'b1, 7'd3};
        vecs[7]  = '{1'b0, 3'd1, 1'b1, 7'd3};
        vecs[8]  = '{1'b1, 3'd3, 1'b0, 7'd3};
        vecs[9]  = '{1'b0, 3'd0, 1'b0, 7'd3};
        vecs[10] = '{1'b0, 3'd2, 1'b1, 7'd1};
        vecs[11] = '{1'b1, 3'd7, 1'b0, 7'd1};
        vecs[12] = '{1'b0, 3'd6, 1'b0, 7'd1};
        vecs[13] = '{1'b1, 3'd4, 1'b1, 7'd0};
        vecs[14] = '{1'b1, 3'd5, 1'b0, 7'd0};
        vecs[15] = '{1'b0, 3'd1, 1'b1, 7'd1};

        do_reset();
        chk("rst_din", DIN, 0);
        chk("rst_acks", {CPU_ACK, BTN_ACK, CMD_ERR}, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_step", STEP_CNT, 0);

        for (int i = 0; i < 16; i++)
            run_vec(i, vecs[i]);

        // Round robin: reset must restore CPU priority (last table grant was CPU).
        do_reset();
        CPU_REQ = 1'b1; CPU_CMD = 3'd1; BTN_REQ = 1'b1; BTN_CMD = 3'd2;
        @(posedge SCLK); #1;
        chk("rr1_cpu_ack", CPU_ACK, 1);
        chk("rr1_btn_ack", BTN_ACK, 0);
        chk("rr1_din", DIN, 1);
        chk("rr1_step", STEP_CNT, 1);
        @(negedge SCLK);
        CPU_REQ = 1'b0;
        for (int c = 2; c <= 7; c++) begin
            @(posedge SCLK); #1;
            chk("rr_busy_btn_ack", BTN_ACK, 0);
            chk("rr_busy", BUSY, 1);
            chk("rr_busy_din", DIN, (c <= HOLD) ? 1 : 0);
        end
        @(posedge SCLK); #1;
        chk("rr_gap_busy", BUSY, 0);
        chk("rr_gap_btn_ack", BTN_ACK, 0);
        @(posedge SCLK); #1;
        chk("rr2_btn_ack", BTN_ACK, 1);
        chk("rr2_cpu_ack", CPU_ACK, 0);
        chk("rr2_din", DIN, 2);
        chk("rr2_step", STEP_CNT, 1);
        @(negedge SCLK);
        BTN_REQ = 1'b0;
        repeat (7) @(posedge SCLK);
        @(negedge SCLK);
        CPU_REQ = 1'b1; CPU_CMD = 3'd4; BTN_REQ = 1'b1; BTN_CMD = 3'd2;
        @(posedge SCLK); #1;
        chk("rr3_cpu_ack", CPU_ACK, 1);
        chk("rr3_btn_ack", BTN_ACK, 0);
        chk("rr3_din", DIN, 4);
        chk("rr3_step", STEP_CNT, 0);
        @(negedge SCLK);
        CPU_REQ = 1'b0; BTN_REQ = 1'b0;
        repeat (8) @(posedge SCLK);

        // Autonomous sweep: RIGHT,RIGHT,RIGHT,LEFT with an 8-cycle period.
        sw_cmd  = '{3'd1, 3'd1, 3'd1, 3'd4};
        sw_step = '{7'd1, 7'd2, 7'd3, 7'd0};
        do_reset();
        SWEEP_EN = 1'b1;
        for (int t = 1; t <= 32; t++) begin
            @(posedge SCLK); #1;
            p = (t - 1) % 8;
            s = (t - 1) / 8;
            chk("sw_din", DIN, (p < HOLD) ? sw_cmd[s] : 0);
            chk("sw_busy", BUSY, (p < 7) ? 1 : 0);
            chk("sw_ack", CPU_ACK | BTN_ACK | CMD_ERR, 0);
            if (p == 0)
                chk("sw_step", STEP_CNT, sw_step[s]);
        end
        CPU_REQ = 1'b1; CPU_CMD = 3'd2;
        @(posedge SCLK); #1;
        chk("sw_pri_ack", CPU_ACK, 1);
        chk("sw_pri_din", DIN, 2);
        chk("sw_pri_step", STEP_CNT, 1);
        CPU_REQ = 1'b0;
        SWEEP_EN = 1'b0;
        repeat (8) @(posedge SCLK);

        // Reset on the third settle cycle, with a new request pending across it.
        do_reset();
        CPU_REQ = 1'b1; CPU_CMD = 3'd1;
        @(posedge SCLK); #1;
        chk("ra_ack", CPU_ACK, 1);
        CPU_REQ = 1'b0;
        repeat (4) @(posedge SCLK);
        #1;
        chk("ra_settle_busy", BUSY, 1);
        chk("ra_settle_din", DIN, 0);
        @(negedge SCLK);
        RESET = 1'b1; CPU_REQ = 1'b1; CPU_CMD = 3'd2;
        @(posedge SCLK); #1;
        chk("ra_rst_din", DIN, 0);
        chk("ra_rst_busy", BUSY, 0);
        chk("ra_rst_step", STEP_CNT, 0);
        chk("ra_rst_ack", CPU_ACK, 0);
        @(negedge SCLK);
        RESET = 1'b0;
        @(posedge SCLK); #1;
        chk("ra_regrant_ack", CPU_ACK, 1);
        chk("ra_regrant_din", DIN, 2);
        chk("ra_regrant_step", STEP_CNT, 1);
        CPU_REQ = 1'b0;
        repeat (8) @(posedge SCLK);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
